// File: rtl/melody_player_if.sv
// melody_player_if: bundles the control, song-ROM and speaker signals of the
// melody player.
//   start, stop, loop : sequencing controls (controller -> player)
//   rom_addr          : song ROM address (player -> ROM)
//   rom_data          : {half_period, dur} entry, one cycle after rom_addr
//   speaker_out       : square-wave tone
//   busy, done        : status; done is a one-cycle end-of-song pulse
// The master modport belongs to the controller/ROM side, slave to the player.
interface melody_player_if #(
  parameter int DIV_W  = 16,
  parameter int DUR_W  = 4,
  parameter int ADDR_W = 5
);
  logic                   start;
  logic                   stop;
  logic                   loop;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DIV_W+DUR_W-1:0] rom_data;
  logic                   speaker_out;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, loop, rom_data,
    input  rom_addr, speaker_out, busy, done
  );

  modport slave (
    input  start, stop, loop, rom_data,
    output rom_addr, speaker_out, busy, done
  );
endinterface

// File: rtl/melody_player.sv
// melody_player: walks a song ROM one entry per note and drives a square wave.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : melody_player_if.slave (start/stop/loop in, rom_addr out,
//          rom_data in, speaker_out/busy/done out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped, silent, waiting for start
// S_FETCH | rom_addr stable, ROM read in flight
// S_LOAD  | rom_data valid; decode end marker or latch the note
// S_PLAY  | tone (or rest) sounding for dur*TICK_CYCLES-GAP_CYCLES cycles
// S_GAP   | silent articulation gap, then next entry or end of song
module melody_player #(
  parameter int DIV_W       = 16,
  parameter int DUR_W       = 4,
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 750000,
  parameter int GAP_CYCLES  = 60000
) (
  input logic             clk,
  input logic             rst,
  melody_player_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] GAP_START = TICK_W'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] rom_addr;
  logic [DIV_W-1:0]  half_period;
  logic [DIV_W-1:0]  tone_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [DUR_W-1:0]  unit_cnt;
  logic              speaker;
  logic              done;

  logic [DIV_W-1:0]  entry_hp;
  logic [DUR_W-1:0]  entry_dur;
  logic              last_unit;
  logic              gap_begin;
  logic              note_end;

  assign entry_hp  = bus.rom_data[DIV_W+DUR_W-1:DUR_W];
  assign entry_dur = bus.rom_data[DUR_W-1:0];

  // Both timers count down across PLAY and GAP as one dur*TICK_CYCLES span;
  // the gap is the final GAP_CYCLES ticks of the last unit.
  assign last_unit = (unit_cnt == '0);
  assign gap_begin = last_unit && (tick_cnt == GAP_START);
  assign note_end  = last_unit && (tick_cnt == '0);

  assign bus.rom_addr    = rom_addr;
  assign bus.speaker_out = speaker;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      half_period <= '0;
      tone_cnt    <= '0;
      tick_cnt    <= '0;
      unit_cnt    <= '0;
      speaker     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && bus.stop) begin
        state   <= S_IDLE;
        speaker <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.stop) begin
              state    <= S_FETCH;
              rom_addr <= '0;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (entry_dur == '0) begin
              if (bus.loop) begin
                rom_addr <= '0;
                state    <= S_FETCH;
              end else begin
                state <= S_IDLE;
                done  <= 1'b1;
              end
            end else begin
              half_period <= entry_hp;
              tone_cnt    <= '0;
              speaker     <= 1'b0;
              tick_cnt    <= TICK_LAST;
              unit_cnt    <= entry_dur - 1'b1;
              state       <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_cnt == '0) begin
              tick_cnt <= TICK_LAST;
              unit_cnt <= unit_cnt - 1'b1;
            end else begin
              tick_cnt <= tick_cnt - 1'b1;
            end
            if (gap_begin) begin
              state   <= S_GAP;
              speaker <= 1'b0;
            end else if (half_period != '0) begin
              if (tone_cnt == half_period - 1'b1) begin
                speaker  <= ~speaker;
                tone_cnt <= '0;
              end else begin
                tone_cnt <= tone_cnt + 1'b1;
              end
            end
          end
          S_GAP: begin
            tick_cnt <= tick_cnt - 1'b1;
            if (note_end) begin
              // Running off the top of the ROM ends the song like a marker.
              if (rom_addr == ADDR_LAST) begin
                if (bus.loop) begin
                  rom_addr <= '0;
                  state    <= S_FETCH;
                end else begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end
              end else begin
                rom_addr <= rom_addr + 1'b1;
                state    <= S_FETCH;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: scoreboard bench for melody_player. A reference model
// expands the ROM contents into the expected per-cycle output trace; a
// monitor pops and compares one entry every cycle after the clock edge.
module tb_melody_player;
  localparam int DIV_W  = 8;
  localparam int DUR_W  = 4;
  localparam int ADDR_W = 3;
  localparam int TICK   = 10;
  localparam int GAP    = 2;
  localparam int N_ENT  = 8;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              spk;
    logic              chk_addr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  melody_player_if #(.DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus();

  melody_player #(
    .DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
    .TICK_CYCLES(TICK), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DIV_W-1:0] rom_hp  [N_ENT];
  logic [DUR_W-1:0] rom_dur [N_ENT];

  always @(posedge clk) bus.rom_data <= {rom_hp[bus.rom_addr], rom_dur[bus.rom_addr]};

  exp_t sb[$];
  exp_t tr[$];
  int   dec[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pop_no = 0;

  // Monitor: one expected entry per cycle, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.speaker_out !== e.spk ||
            (e.chk_addr && bus.rom_addr !== e.addr)) begin
          n_err++;
          $display("FAIL trace[%0d]: got busy=%b done=%b spk=%b addr=%0d, want busy=%b done=%b spk=%b addr=%0d",
                   pop_no, bus.busy, bus.done, bus.speaker_out, bus.rom_addr,
                   e.busy, e.done, e.spk, e.addr);
        end
        pop_no++;
      end
    end
  end

  function automatic void push_e(bit b, bit d, bit s, bit c, int a);
    exp_t e;
    e.busy = b; e.done = d; e.spk = s; e.chk_addr = c; e.addr = ADDR_W'(a);
    tr.push_back(e);
  endfunction

  // Expected trace, index k = outputs after the k-th edge from the start edge.
  task automatic build_song(input int n_loops);
    int a;
    int loops_left;
    bit fin;
    bit at_end;
    tr.delete();
    dec.delete();
    a = 0;
    loops_left = n_loops;
    fin = 1'b0;
    while (!fin) begin
      push_e(1, 0, 0, 1, a);
      push_e(1, 0, 0, 1, a);
      at_end = 1'b0;
      if (rom_dur[a] == 0) begin
        at_end = 1'b1;
      end else begin
        int play_len = int'(rom_dur[a]) * TICK - GAP;
        int hp = int'(rom_hp[a]);
        for (int j = 0; j < play_len; j++)
          push_e(1, 0, (hp == 0) ? 1'b0 : bit'((j / hp) % 2), 1, a);
        for (int j = 0; j < GAP; j++)
          push_e(1, 0, 0, 1, a);
        if (a == N_ENT - 1) at_end = 1'b1;
        else a++;
      end
      if (at_end) begin
        dec.push_back(tr.size() - 1);
        if (loops_left > 0) begin
          loops_left--;
          a = 0;
        end else begin
          fin = 1'b1;
        end
      end
    end
    push_e(0, 1, 0, 0, 0);
    push_e(0, 0, 0, 0, 0);
    push_e(0, 0, 0, 0, 0);
  endtask

  task automatic wait_drain(input int limit);
    for (int m = 0; m < limit && sb.size() > 0; m++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Plays the current ROM; optional stop at edge stop_at, stray start at edge extra_start.
  task automatic run_song(input int n_loops, input int stop_at, input int extra_start);
    int lim;
    build_song(n_loops);
    if (stop_at >= 0) begin
      while (tr.size() > stop_at) void'(tr.pop_back());
      for (int i = 0; i < 3; i++) push_e(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.loop  = (n_loops > 0);
    foreach (tr[i]) sb.push_back(tr[i]);
    lim = sb.size() + 20;
    for (int m = 0; m < lim && sb.size() > 0; m++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (n_loops > 0 && m == dec[n_loops-1] + 1) bus.loop = 1'b0;
      if (m + 1 == stop_at) bus.stop = 1'b1;
      if (m + 1 == extra_start) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    wait_drain(5);
  endtask

  task automatic load_basic();
    for (int i = 0; i < N_ENT; i++) begin
      rom_hp[i] = 8'd7; rom_dur[i] = 4'd3;
    end
    rom_hp[0] = 8'd4; rom_dur[0] = 4'd2;
    rom_hp[1] = 8'd0; rom_dur[1] = 4'd1;
    rom_hp[2] = 8'd9; rom_dur[2] = 4'd0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    load_basic();
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.speaker_out !== 1'b0 || bus.rom_addr !== '0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b spk=%b addr=%0d, want all 0",
               bus.busy, bus.done, bus.speaker_out, bus.rom_addr);
    end
    rst = 1'b0;

    // basic song, then looping once, then contention with a stray start
    run_song(0, -1, -1);
    run_song(1, -1, -1);
    run_song(0, -1, 15);

    // stop mid-note, then restart from address 0
    run_song(0, 12, -1);
    run_song(0, -1, -1);

    // start+stop together in IDLE stays idle
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tr.delete();
    for (int i = 0; i < 4; i++) push_e(0, 0, 0, 0, 0);
    foreach (tr[i]) sb.push_back(tr[i]);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    wait_drain(10);

    // address wrap: no marker, eight one-tick notes
    for (int i = 0; i < N_ENT; i++) begin
      rom_hp[i] = 8'd2; rom_dur[i] = 4'd1;
    end
    run_song(0, -1, -1);

    // asynchronous reset while the tone is high
    for (int i = 0; i < N_ENT; i++) begin
      rom_hp[i] = 8'd3; rom_dur[i] = 4'd2;
    end
    build_song(0);
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 7; i++) sb.push_back(tr[i]);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    wait_drain(3);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.speaker_out !== 1'b0 || bus.rom_addr !== '0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b spk=%b addr=%0d, want all 0",
               bus.busy, bus.done, bus.speaker_out, bus.rom_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_song(0, -1, -1);

    // randomized songs
    for (int t = 0; t < 8; t++) begin
      int mk;
      mk = $urandom_range(0, 9);
      for (int i = 0; i < N_ENT; i++) begin
        rom_hp[i]  = DIV_W'($urandom_range(0, 5));
        rom_dur[i] = DUR_W'($urandom_range(1, 3));
      end
      if (mk < N_ENT) rom_dur[mk] = '0;
      run_song($urandom_range(0, 1), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
